// File: rtl/sprite_pixel_scheduler.sv
// rtl/sprite_pixel_scheduler.sv - shared sprite ROM read scheduler with priority scan and colour-key fall-through
//
// Purpose: for each requested pixel, scans objects in priority order (index 0
// first), reads the texel of every object covering the pixel from one shared
// frame-RAM port, skips transparent texels (== KEY) and returns the first opaque
// colour, or BG when nothing opaque covers the pixel.
//
// Ports:
//   Clk, Reset          clock, synchronous active-high reset
//   pix_req             one-cycle start pulse; DrawX/DrawY and object state latched
//   DrawX, DrawY        pixel coordinates
//   obj_en/x/y/base     packed per-object enable, top-left corner, ROM frame base
//   rom_addr, rom_rd    registered ROM read request (one-cycle strobe)
//   rom_data            ROM read data, valid ROM_LAT cycles after rom_rd
//   pix_rgb, pix_valid  resolved colour (held) and its one-cycle valid pulse
//   busy                a pixel is in flight
//   overrun             pix_req arrived while busy and was dropped

module sprite_pixel_scheduler #(
  parameter int          NUM_OBJ = 4,
  parameter int          SPR_W   = 50,
  parameter int          SPR_H   = 50,
  parameter int          ADDR_W  = 19,
  parameter int          ROM_LAT = 1,
  parameter logic [23:0] KEY     = 24'hFF0000,
  parameter logic [23:0] BG      = 24'hFFFFFF
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      pix_req,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic [NUM_OBJ-1:0]        obj_en,
  input  logic [NUM_OBJ*10-1:0]     obj_x,
  input  logic [NUM_OBJ*10-1:0]     obj_y,
  input  logic [NUM_OBJ*ADDR_W-1:0] obj_base,
  output logic [ADDR_W-1:0]         rom_addr,
  output logic                      rom_rd,
  input  logic [23:0]               rom_data,
  output logic [23:0]               pix_rgb,
  output logic                      pix_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int LAT_W = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);
  localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(ROM_LAT);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WAIT, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [LAT_W-1:0]            lat_q, lat_d;
  logic [9:0]                  draw_x_q, draw_x_d, draw_y_q, draw_y_d;
  logic [NUM_OBJ-1:0]          en_q, en_d;
  logic [NUM_OBJ*10-1:0]       x_q, x_d, y_q, y_d;
  logic [NUM_OBJ*ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]           rom_addr_q, rom_addr_d;
  logic                        rom_rd_q, rom_rd_d;
  logic [23:0]                 pix_rgb_q, pix_rgb_d;
  logic                        pix_valid_q, pix_valid_d;

  // Currently scanned object, taken from the latched snapshot
  logic              cur_en;
  logic [9:0]        cur_x, cur_y, dx, dy;
  logic [10:0]       x_end, y_end;
  logic [ADDR_W-1:0] cur_base, rd_addr;
  logic              hit;

  always_comb begin
    cur_en   = en_q[idx_q];
    cur_x    = x_q[int'(idx_q)*10 +: 10];
    cur_y    = y_q[int'(idx_q)*10 +: 10];
    cur_base = base_q[int'(idx_q)*ADDR_W +: ADDR_W];
    // 11-bit right/bottom edges so objects near the screen edge cannot wrap
    x_end    = {1'b0, cur_x} + 11'(SPR_W);
    y_end    = {1'b0, cur_y} + 11'(SPR_H);
    hit      = cur_en &&
               ({1'b0, draw_x_q} >= {1'b0, cur_x}) && ({1'b0, draw_x_q} < x_end) &&
               ({1'b0, draw_y_q} >= {1'b0, cur_y}) && ({1'b0, draw_y_q} < y_end);
    dx       = draw_x_q - cur_x;
    dy       = draw_y_q - cur_y;
    rd_addr  = cur_base + ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lat_d       = lat_q;
    draw_x_d    = draw_x_q;
    draw_y_d    = draw_y_q;
    en_d        = en_q;
    x_d         = x_q;
    y_d         = y_q;
    base_d      = base_q;
    rom_addr_d  = rom_addr_q;
    rom_rd_d    = 1'b0;
    pix_rgb_d   = pix_rgb_q;
    pix_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pix_req) begin
          draw_x_d = DrawX;
          draw_y_d = DrawY;
          en_d     = obj_en;
          x_d      = obj_x;
          y_d      = obj_y;
          base_d   = obj_base;
          idx_d    = '0;
          state_d  = S_SCAN;
        end
      end
      S_SCAN: begin
        if (hit) begin
          rom_addr_d = rd_addr;
          rom_rd_d   = 1'b1;
          lat_d      = '0;
          state_d    = S_WAIT;
        end else if (idx_q == LAST_IDX) begin
          pix_rgb_d   = BG;
          pix_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_WAIT: begin
        // lat_q counts cycles since the rom_rd cycle; data is sampled at ROM_LAT
        if (lat_q == LAT_END) begin
          if (rom_data != KEY) begin
            pix_rgb_d   = rom_data;
            pix_valid_d = 1'b1;
            state_d     = S_DONE;
          end else if (idx_q == LAST_IDX) begin
            pix_rgb_d   = BG;
            pix_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SCAN;
          end
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      lat_q       <= '0;
      draw_x_q    <= '0;
      draw_y_q    <= '0;
      en_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      base_q      <= '0;
      rom_addr_q  <= '0;
      rom_rd_q    <= 1'b0;
      pix_rgb_q   <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lat_q       <= lat_d;
      draw_x_q    <= draw_x_d;
      draw_y_q    <= draw_y_d;
      en_q        <= en_d;
      x_q         <= x_d;
      y_q         <= y_d;
      base_q      <= base_d;
      rom_addr_q  <= rom_addr_d;
      rom_rd_q    <= rom_rd_d;
      pix_rgb_q   <= pix_rgb_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rom_rd    = rom_rd_q;
  assign pix_rgb   = pix_rgb_q;
  assign pix_valid = pix_valid_q;
  assign busy      = (state_q != S_IDLE);
  // Flags the dropped request in the same cycle it is presented
  assign overrun   = pix_req && (state_q != S_IDLE);

endmodule

// File: tb/tb_sprite_pixel_scheduler.sv
// tb/tb_sprite_pixel_scheduler.sv - self-checking bench for sprite_pixel_scheduler
module tb_sprite_pixel_scheduler;

  localparam int          NUM_OBJ = 4;
  localparam int          ADDR_W  = 19;
  localparam logic [23:0] KEY     = 24'hFF0000;
  localparam logic [23:0] BG      = 24'hFFFFFF;

  logic                      Clk = 1'b0;
  logic                      Reset = 1'b1;
  logic                      pix_req = 1'b0;
  logic [9:0]                DrawX = '0;
  logic [9:0]                DrawY = '0;
  logic [NUM_OBJ-1:0]        obj_en;
  logic [NUM_OBJ*10-1:0]     obj_x, obj_y;
  logic [NUM_OBJ*ADDR_W-1:0] obj_base;
  logic [ADDR_W-1:0]         rom_addr;
  logic                      rom_rd;
  logic [23:0]               rom_data = '0;
  logic [23:0]               pix_rgb;
  logic                      pix_valid, busy, overrun;

  logic [NUM_OBJ-1:0] en_b;
  logic [9:0]         ox [NUM_OBJ];
  logic [9:0]         oy [NUM_OBJ];
  logic [ADDR_W-1:0]  ob [NUM_OBJ];

  assign obj_en = en_b;
  for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_pack
    assign obj_x[10*gi +: 10]        = ox[gi];
    assign obj_y[10*gi +: 10]        = oy[gi];
    assign obj_base[ADDR_W*gi +: ADDR_W] = ob[gi];
  end

  sprite_pixel_scheduler dut (
    .Clk(Clk), .Reset(Reset), .pix_req(pix_req), .DrawX(DrawX), .DrawY(DrawY),
    .obj_en(obj_en), .obj_x(obj_x), .obj_y(obj_y), .obj_base(obj_base),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data),
    .pix_rgb(pix_rgb), .pix_valid(pix_valid), .busy(busy), .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Frame-RAM model: one-cycle registered read
  logic [23:0] rom_mem [int];
  function automatic logic [23:0] rom_val(int a);
    if (rom_mem.exists(a)) return rom_mem[a];
    return 24'h800000 | 24'(a);
  endfunction
  always @(posedge Clk) if (rom_rd) rom_data <= rom_val(int'(rom_addr));

  // Expected behaviour, keyed by cycle number
  bit exp_busy  [int];
  int exp_rd    [int];
  int exp_valid [int];
  int rgb_set   [int];
  bit exp_ovr   [int];

  int vectors = 0, miscompares = 0;
  bit checking = 0;
  int cur_rgb = 0;
  int last_done, last_rgb, last_nrd, last_addr0;

  function automatic void chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // Walk objects in priority order; each miss costs one cycle, each read three
  // (scan, request, data); done lands at the cycle after the last step.
  function automatic void model_pixel(int t, int px, int py);
    int  s = t + 1;
    bit  found = 0;
    int  rgb = BG;
    last_nrd   = 0;
    last_addr0 = -1;
    for (int i = 0; i < NUM_OBJ && !found; i++) begin
      int x = int'(ox[i]);
      int y = int'(oy[i]);
      int b = int'(ob[i]);
      if (en_b[i] && px >= x && px < x + 50 && py >= y && py < y + 50) begin
        int a = (b + (py - y) * 50 + (px - x)) % (1 << ADDR_W);
        exp_rd[s + 1] = a;
        if (last_nrd == 0) last_addr0 = a;
        last_nrd++;
        if (rom_val(a) != KEY) begin
          rgb   = int'(rom_val(a));
          found = 1;
        end
        s += 3;
      end else begin
        s += 1;
      end
    end
    for (int c = t + 1; c <= s; c++) exp_busy[c] = 1;
    exp_valid[s] = rgb;
    last_done    = s;
    last_rgb     = rgb;
  endfunction

  always @(negedge Clk) begin
    if (checking) begin
      if (rgb_set.exists(cyc)) cur_rgb = rgb_set[cyc];
      if (exp_valid.exists(cyc)) cur_rgb = exp_valid[cyc];
      chk("busy", int'(busy), int'(exp_busy.exists(cyc)));
      chk("rom_rd", int'(rom_rd), int'(exp_rd.exists(cyc)));
      if (exp_rd.exists(cyc)) chk("rom_addr", int'(rom_addr), exp_rd[cyc]);
      chk("pix_valid", int'(pix_valid), int'(exp_valid.exists(cyc)));
      chk("pix_rgb", int'(pix_rgb), cur_rgb);
      chk("overrun", int'(overrun), int'(exp_ovr.exists(cyc)));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic clear_objs();
    en_b = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      ox[i] = '0; oy[i] = '0; ob[i] = '0;
    end
  endtask

  task automatic set_obj(input int i, input int x, input int y, input int base);
    en_b[i] = 1'b1;
    ox[i] = 10'(x); oy[i] = 10'(y); ob[i] = ADDR_W'(base);
  endtask

  // Pulse pix_req, then scramble object/pixel inputs for one cycle to show the
  // snapshot is used, then restore. Returns two cycles after the request.
  task automatic pixel(input int px, input int py);
    int t = cyc;
    logic [NUM_OBJ-1:0] se;
    logic [9:0] sx [NUM_OBJ];
    logic [9:0] sy [NUM_OBJ];
    logic [ADDR_W-1:0] sb [NUM_OBJ];
    if (exp_busy.exists(t)) exp_ovr[t] = 1;
    else model_pixel(t, px, py);
    DrawX = 10'(px); DrawY = 10'(py); pix_req = 1'b1;
    step(1);
    pix_req = 1'b0;
    se = en_b;
    for (int i = 0; i < NUM_OBJ; i++) begin
      sx[i] = ox[i]; sy[i] = oy[i]; sb[i] = ob[i];
      ox[i] = ~ox[i]; oy[i] = ~oy[i]; ob[i] = ob[i] ^ 19'h2AAAA;
    end
    en_b = ~en_b; DrawX = ~DrawX; DrawY = ~DrawY;
    step(1);
    en_b = se;
    for (int i = 0; i < NUM_OBJ; i++) begin
      ox[i] = sx[i]; oy[i] = sy[i]; ob[i] = sb[i];
    end
  endtask

  task automatic reset_now();
    int r = cyc;
    int ks[$];
    Reset = 1'b1;
    foreach (exp_busy[k]) if (k > r) ks.push_back(k);
    foreach (ks[j]) exp_busy.delete(ks[j]);
    ks.delete();
    foreach (exp_rd[k]) if (k > r) ks.push_back(k);
    foreach (ks[j]) exp_rd.delete(ks[j]);
    ks.delete();
    foreach (exp_valid[k]) if (k > r) ks.push_back(k);
    foreach (ks[j]) exp_valid.delete(ks[j]);
    ks.delete();
    foreach (exp_ovr[k]) if (k > r) ks.push_back(k);
    foreach (ks[j]) exp_ovr.delete(ks[j]);
    rgb_set[r + 1] = 0;
    step(1);
    Reset = 1'b0;
  endtask

  initial begin
    int t;
    clear_objs();
    Reset = 1'b1;
    step(3);
    Reset = 1'b0;
    checking = 1;
    chk("reset_rom_addr", int'(rom_addr), 0);
    chk("reset_pix_rgb", int'(pix_rgb), 0);
    step(2);

    // Single opaque hit on obj0
    clear_objs(); set_obj(0, 100, 100, 0);
    rom_mem[260] = 24'h00FF00;
    t = cyc; pixel(110, 105);
    chk("pin_opaque_latency", last_done - t, 4);
    chk("pin_opaque_addr", last_addr0, 260);
    chk("pin_opaque_rgb", last_rgb, 24'h00FF00);
    step(12);

    // Transparent obj0 falls through to obj1
    clear_objs(); set_obj(0, 100, 100, 0); set_obj(1, 100, 100, 2500);
    rom_mem[260] = KEY; rom_mem[2760] = 24'h123456;
    t = cyc; pixel(110, 105);
    chk("pin_fall_reads", last_nrd, 2);
    chk("pin_fall_rgb", last_rgb, 24'h123456);
    chk("pin_fall_latency", last_done - t, 7);
    step(12);

    // All disabled
    clear_objs();
    t = cyc; pixel(110, 105);
    chk("pin_miss_latency", last_done - t, 5);
    chk("pin_miss_rgb", last_rgb, BG);
    step(12);

    // All enabled, pixel outside, then one lower-priority hit
    clear_objs();
    for (int i = 0; i < NUM_OBJ; i++) set_obj(i, 100 + i * 60, 200, i * 2500);
    pixel(0, 0); step(12);
    pixel(170, 210);
    chk("pin_obj1_addr", last_addr0, 3010);
    step(12);

    // Box edges
    clear_objs(); set_obj(0, 100, 100, 0);
    pixel(149, 100);
    chk("pin_edge_x_addr", last_addr0, 49);
    step(12);
    pixel(150, 100); step(12);
    pixel(120, 149); step(12);
    pixel(120, 150);
    chk("pin_edge_y_miss", last_nrd, 0);
    step(12);

    // Right screen edge, no wrap
    clear_objs(); set_obj(0, 1000, 0, 1000);
    pixel(1020, 10);
    chk("pin_right_addr", last_addr0, 1520);
    step(12);
    pixel(5, 10);
    chk("pin_nowrap_rgb", last_rgb, BG);
    step(12);

    // Every object hit and transparent
    clear_objs();
    for (int i = 0; i < NUM_OBJ; i++) begin
      set_obj(i, 0, 0, i * 2500);
      rom_mem[i * 2500 + 51] = KEY;
    end
    t = cyc; pixel(1, 1);
    chk("pin_alltrans_latency", last_done - t, 13);
    step(12);

    // Priority: obj0 wins over overlapping obj1
    clear_objs(); set_obj(0, 300, 300, 10000); set_obj(1, 290, 290, 20000);
    pixel(310, 310);
    chk("pin_prio_reads", last_nrd, 1);
    step(12);

    // Address truncation to ADDR_W
    clear_objs(); set_obj(0, 100, 100, 524287);
    pixel(110, 105);
    chk("pin_trunc_addr", last_addr0, 259);
    step(12);

    // Overrun at t+2 and in the DONE cycle t+4
    clear_objs(); set_obj(0, 100, 100, 0);
    rom_mem[260] = 24'h00FF00;
    pixel(110, 105);
    pixel(20, 20);
    pixel(20, 20);
    step(12);

    // Reset in WAIT, then normal service
    pixel(110, 105);
    step(1);
    reset_now();
    step(3);
    pixel(110, 105);
    step(12);

    checking = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sprite_pixel_scheduler.md
Name: sprite_pixel_scheduler

Overview:
- Time-multiplexes one shared sprite frame-RAM read port across NUM_OBJ on-screen objects (tanks, shells).
- For each requested pixel it scans objects in priority order and issues ROM reads for each object that covers the pixel.
- A fetched texel equal to KEY is transparent, so the scan falls through to the next object.
- Returns the final 24-bit colour to the colour-mapping stage. Sits between the VGA/frame logic and the sprite frame-RAMs.

Parameters:
NUM_OBJ, 4, number of objects; index 0 is highest priority
SPR_W, 50, sprite width in pixels
SPR_H, 50, sprite height in pixels
ADDR_W, 19, sprite ROM address width
ROM_LAT, 1, ROM read latency in Clk cycles (registered frame-RAM)
KEY, 24'hFF0000, transparent texel value
BG, 24'hFFFFFF, background colour

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
pix_req  in  1  one-cycle pulse: DrawX/DrawY valid, start pixel
DrawX  in  10  pixel column
DrawY  in  10  pixel row
obj_en  in  NUM_OBJ  per-object enable
obj_x  in  NUM_OBJ*10  packed object top-left X; object i at [10*i+:10]
obj_y  in  NUM_OBJ*10  packed object top-left Y
obj_base  in  NUM_OBJ*ADDR_W  packed ROM base address of each object's current frame (direction)
rom_addr  out  ADDR_W  ROM read address, registered
rom_rd  out  1  ROM read strobe, registered
rom_data  in  24  ROM read data, valid ROM_LAT cycles after rom_rd
pix_rgb  out  24  resolved colour, registered
pix_valid  out  1  one-cycle pulse: pix_rgb valid
busy  out  1  high whenever state != IDLE
overrun  out  1  one-cycle pulse: pix_req dropped

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous, active-high.
- Reset values: state=IDLE, idx=0, rom_addr=0, rom_rd=0, pix_rgb=0, pix_valid=0, busy=0, overrun=0.
- States: IDLE, SCAN, WAIT, DONE.
- IDLE, on pix_req:
  - latch DrawX, DrawY, obj_en, obj_x, obj_y, obj_base;
  - set idx=0;
  - go to SCAN.
  - Object inputs changing mid-pixel have no effect.
- SCAN, one object per cycle:
  - Hit test: obj_en[idx] && DrawX>=x && DrawX<x+SPR_W && DrawY>=y && DrawY<y+SPR_H.
  - Comparisons use 11-bit sums, so x+SPR_W>1023 does not wrap.
  - Hit: next cycle rom_addr = base + (DrawY-y)*SPR_W + (DrawX-x), truncated to ADDR_W; rom_rd=1 for exactly that cycle; go to WAIT.
  - Miss, idx<NUM_OBJ-1: idx++, stay in SCAN.
  - Miss, idx==NUM_OBJ-1: pix_rgb=BG, go to DONE.
- WAIT:
  - Sample rom_data ROM_LAT cycles after the rom_rd cycle.
  - rom_data != KEY: pix_rgb=rom_data, go to DONE.
  - rom_data == KEY, idx<NUM_OBJ-1: idx++, go to SCAN.
  - rom_data == KEY, last object: pix_rgb=BG, go to DONE.
- DONE: pix_valid=1 for this one cycle; go to IDLE.
- pix_rgb holds its value until the next DONE.
- Latency, pix_req at cycle t (ROM_LAT=1):
  - obj0 opaque hit: pix_valid at t+4.
  - no hits: pix_valid at t+1+NUM_OBJ (t+5).
  - every object hit and transparent: t+1+NUM_OBJ*(ROM_LAT+2) (t+13).
- Overrun: pix_req in any state other than IDLE (including DONE) is dropped and overrun pulses the same cycle. The in-flight pixel is unaffected.
- Reset mid-operation: next cycle is IDLE with all outputs at reset values. No pix_valid for the aborted pixel; a late rom_data return is ignored.
- rom_rd is never asserted outside the cycle after a SCAN hit. At most one read is outstanding.

Test Plan:
- Single opaque hit: obj0 en, x=100, y=100, base=0; DrawX=110, DrawY=105, rom_data=24'h00FF00 -> rom_addr=260, rom_rd one cycle, pix_valid at t+4, pix_rgb=24'h00FF00.
- Transparent fall-through: obj0 and obj1 overlap, obj1 base=2500; ROM returns FF0000 for obj0 and 24'h123456 for obj1 -> two rom_rd pulses, second at address 2500+offset, pix_rgb=24'h123456.
- Miss everywhere: all obj_en=0 or DrawX=0 outside all objects -> no rom_rd, pix_valid at t+5, pix_rgb=FFFFFF.
- Edge bounds: x=100 with DrawX=149 -> hit; DrawX=150 -> miss. x=1000, DrawX=1020 -> hit, with no wrap false-hit at DrawX=5.
- Overrun: second pix_req at t+2 -> overrun=1 at t+2, only one pix_valid, busy high t+1..t+4.
- Reset in WAIT: assert Reset the cycle after rom_rd -> next cycle IDLE, pix_valid stays 0, and a following pix_req is serviced normally.
